// File: rtl/spi_slave_core.sv
// SPI slave on the system clock: synchronised pins, mode 0..3, valid/ready rx and tx buffers.
// Optional echo mode: define SPI_LOOPBACK_EN to reload the last received word when no tx word is queued.
module spi_slave_core #(
  parameter int WIDTH     = 8,
  parameter int MODE      = 0,
  parameter int MSB_FIRST = 1,
  parameter int LED_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [LED_W-1:0] leds
);

  localparam bit CPOL = ((MODE >> 1) & 1) == 1;
  localparam bit CPHA = (MODE & 1) == 1;
  localparam int CW   = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] tx_buf;
  logic             tx_full;
  logic             miso_r;
  logic             skip_shift;
  logic             done_p1;
  logic [WIDTH-1:0] word_p1;
  logic             sclk_meta, sclk_p0, sclk_prev;
  logic             cs_meta, cs_p0, cs_prev;
  logic             mosi_meta, mosi_p0;

  function automatic logic tx_head(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] tx_shift(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] rx_shift(input logic [WIDTH-1:0] v, input logic b);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], b} : {b, v[WIDTH-1:1]};
  endfunction

  // Stage p0: two-flop synchronisers plus previous sclk/cs for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_meta <= 1'b0;
      sclk_p0   <= 1'b0;
      sclk_prev <= 1'b0;
      cs_meta   <= 1'b0;
      cs_p0     <= 1'b0;
      cs_prev   <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_p0   <= 1'b0;
    end else begin
      sclk_meta <= sclk;
      sclk_p0   <= sclk_meta;
      sclk_prev <= sclk_p0;
      cs_meta   <= cs;
      cs_p0     <= cs_meta;
      cs_prev   <= cs_p0;
      mosi_meta <= mosi;
      mosi_p0   <= mosi_meta;
    end
  end

  logic rise, fall, lead, trail, sample_edge, shift_edge, cs_rise, cs_fall;
  logic word_end, do_load;
  logic [WIDTH-1:0] load_val;

  assign rise        = sclk_p0 & ~sclk_prev;
  assign fall        = ~sclk_p0 & sclk_prev;
  assign lead        = CPOL ? fall : rise;
  assign trail       = CPOL ? rise : fall;
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;
  assign cs_rise     = cs_p0 & ~cs_prev;
  assign cs_fall     = ~cs_p0 & cs_prev;
  assign word_end    = (state == ACTIVE) && !cs_fall && sample_edge &&
                       (bit_cnt == CW'(WIDTH - 1));
  assign do_load     = ((state == IDLE) && cs_rise) || word_end;

  always_comb begin
    load_val = '0;
    if (tx_full) begin
      load_val = tx_buf;
    end else begin
`ifdef SPI_LOOPBACK_EN
      load_val = rx_data;
`else
      load_val = '0;
`endif
    end
  end

  // Stage p1: FSM, bit counter, shift registers and transmit buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      tx_buf     <= '0;
      tx_full    <= 1'b0;
      miso_r     <= 1'b0;
      skip_shift <= 1'b0;
      done_p1    <= 1'b0;
      word_p1    <= '0;
    end else begin
      done_p1 <= 1'b0;

      if (tx_valid && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end else if (do_load && tx_full) begin
        tx_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          miso_r     <= 1'b0;
          bit_cnt    <= '0;
          skip_shift <= 1'b0;
          if (cs_rise) begin
            state <= ACTIVE;
            if (!CPHA) begin
              miso_r <= tx_head(load_val);
              tx_sr  <= tx_shift(load_val);
            end else begin
              tx_sr  <= load_val;
            end
          end
        end
        ACTIVE: begin
          if (cs_fall) begin
            state   <= IDLE;
            miso_r  <= 1'b0;
            bit_cnt <= '0;
          end else begin
            if (sample_edge) begin
              if (word_end) begin
                bit_cnt <= '0;
                done_p1 <= 1'b1;
                word_p1 <= rx_shift(rx_sr, mosi_p0);
                // In CPHA=0 the next word's first bit goes out now, so the
                // trailing edge that follows must not shift it away.
                if (!CPHA) begin
                  miso_r     <= tx_head(load_val);
                  tx_sr      <= tx_shift(load_val);
                  skip_shift <= 1'b1;
                end else begin
                  tx_sr <= load_val;
                end
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
                rx_sr   <= rx_shift(rx_sr, mosi_p0);
              end
            end
            if (shift_edge) begin
              if (!CPHA && skip_shift) begin
                skip_shift <= 1'b0;
              end else begin
                miso_r <= tx_head(tx_sr);
                tx_sr  <= tx_shift(tx_sr);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p2: receive handshake, overrun flag and led mirror
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      leds       <= '0;
    end else if (done_p1) begin
      if (!rx_valid || rx_ready) begin
        rx_data  <= word_p1;
        leds     <= word_p1[LED_W-1:0];
        rx_valid <= 1'b1;
      end else begin
        rx_overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  assign miso     = miso_r;
  assign tx_ready = ~tx_full;

endmodule
